// File: rtl/lowrisc_chip_pkg.sv
// Shared types and constants for the lowRISC bring-up shell: UART state encoding,
// boot banner and default timing parameters.
package lowrisc_chip_pkg;

   localparam int unsigned DEF_CLKS_PER_BIT = 868;
   localparam int unsigned DEF_RST_STRETCH  = 16;
   localparam int unsigned BANNER_LEN       = 9;

   typedef enum logic [1:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_STOP
   } uart_state_e;

   // "lowRISC\r\n"
   localparam logic [7:0] BANNER [BANNER_LEN] = '{
      8'h6C, 8'h6F, 8'h77, 8'h52, 8'h49, 8'h53, 8'h43, 8'h0D, 8'h0A
   };

   function automatic logic [7:0] banner_byte(input logic [3:0] idx);
      logic [7:0] v;
      v = 8'h00;
      for (int unsigned i = 0; i < BANNER_LEN; i++) begin
         if (32'(idx) == i) v = BANNER[i];
      end
      return v;
   endfunction

endpackage

// File: rtl/chip_uart.sv
// 8N1 UART: transmitter with byte valid/ready handshake, receiver with a
// 2-flop synchroniser and a one-cycle valid pulse per good byte.
module chip_uart
   import lowrisc_chip_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_tx_valid,
   input  logic [7:0] i_tx_data,
   output logic       o_tx_ready_c,
   output logic       o_txd,
   input  logic       i_rxd,
   output logic       o_rx_valid,
   output logic [7:0] o_rx_data
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   uart_state_e     r_tx_state, w_tx_state_n;
   logic [CW-1:0]   r_tx_cnt, w_tx_cnt_n;
   logic [2:0]      r_tx_idx, w_tx_idx_n;
   logic [7:0]      r_tx_shift, w_tx_shift_n;
   logic            r_txd, w_txd_n;

   uart_state_e     r_rx_state, w_rx_state_n;
   logic [CW-1:0]   r_rx_cnt, w_rx_cnt_n;
   logic [2:0]      r_rx_idx, w_rx_idx_n;
   logic [7:0]      r_rx_shift, w_rx_shift_n;
   logic            r_rx_valid, w_rx_valid_n;
   logic            r_rx_s1, r_rx_s2, r_rx_prev;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tx_state <= UART_IDLE;
         r_tx_cnt   <= '0;
         r_tx_idx   <= '0;
         r_tx_shift <= '0;
         r_txd      <= 1'b1;
      end else begin
         r_tx_state <= w_tx_state_n;
         r_tx_cnt   <= w_tx_cnt_n;
         r_tx_idx   <= w_tx_idx_n;
         r_tx_shift <= w_tx_shift_n;
         r_txd      <= w_txd_n;
      end
   end

   // TX: the next byte may be taken at the last stop-bit cycle, giving gapless frames
   always_comb begin
      w_tx_state_n = r_tx_state;
      w_tx_cnt_n   = r_tx_cnt + CW'(1);
      w_tx_idx_n   = r_tx_idx;
      w_tx_shift_n = r_tx_shift;
      w_txd_n      = r_txd;
      o_tx_ready_c = 1'b0;
      unique case (r_tx_state)
         UART_IDLE: begin
            o_tx_ready_c = 1'b1;
            w_tx_cnt_n   = '0;
            w_txd_n      = 1'b1;
            if (i_tx_valid) begin
               w_tx_shift_n = i_tx_data;
               w_tx_state_n = UART_START;
               w_txd_n      = 1'b0;
            end
         end
         UART_START: begin
            if (r_tx_cnt == BIT_LAST) begin
               w_tx_cnt_n   = '0;
               w_tx_idx_n   = '0;
               w_tx_state_n = UART_DATA;
               w_txd_n      = r_tx_shift[0];
            end
         end
         UART_DATA: begin
            if (r_tx_cnt == BIT_LAST) begin
               w_tx_cnt_n = '0;
               if (r_tx_idx == 3'd7) begin
                  w_tx_state_n = UART_STOP;
                  w_txd_n      = 1'b1;
               end else begin
                  w_tx_idx_n   = r_tx_idx + 3'd1;
                  w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                  w_txd_n      = r_tx_shift[1];
               end
            end
         end
         UART_STOP: begin
            if (r_tx_cnt == BIT_LAST) begin
               w_tx_cnt_n   = '0;
               o_tx_ready_c = 1'b1;
               if (i_tx_valid) begin
                  w_tx_shift_n = i_tx_data;
                  w_tx_state_n = UART_START;
                  w_txd_n      = 1'b0;
               end else begin
                  w_tx_state_n = UART_IDLE;
                  w_txd_n      = 1'b1;
               end
            end
         end
         default: w_tx_state_n = UART_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_state <= UART_IDLE;
         r_rx_cnt   <= '0;
         r_rx_idx   <= '0;
         r_rx_shift <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_s1    <= i_rxd;
         r_rx_s2    <= r_rx_s1;
         r_rx_prev  <= r_rx_s2;
         r_rx_state <= w_rx_state_n;
         r_rx_cnt   <= w_rx_cnt_n;
         r_rx_idx   <= w_rx_idx_n;
         r_rx_shift <= w_rx_shift_n;
         r_rx_valid <= w_rx_valid_n;
      end
   end

   // RX: arming on a falling edge means a framing error waits for the line to go high
   always_comb begin
      w_rx_state_n = r_rx_state;
      w_rx_cnt_n   = r_rx_cnt + CW'(1);
      w_rx_idx_n   = r_rx_idx;
      w_rx_shift_n = r_rx_shift;
      w_rx_valid_n = 1'b0;
      unique case (r_rx_state)
         UART_IDLE: begin
            w_rx_cnt_n = '0;
            if (r_rx_prev && !r_rx_s2) w_rx_state_n = UART_START;
         end
         UART_START: begin
            if (r_rx_cnt == HALF_LAST) begin
               w_rx_cnt_n = '0;
               w_rx_idx_n = '0;
               w_rx_state_n = r_rx_s2 ? UART_IDLE : UART_DATA;
            end
         end
         UART_DATA: begin
            if (r_rx_cnt == BIT_LAST) begin
               w_rx_cnt_n   = '0;
               w_rx_shift_n = {r_rx_s2, r_rx_shift[7:1]};
               if (r_rx_idx == 3'd7) w_rx_state_n = UART_STOP;
               else                  w_rx_idx_n   = r_rx_idx + 3'd1;
            end
         end
         UART_STOP: begin
            if (r_rx_cnt == BIT_LAST) begin
               w_rx_cnt_n   = '0;
               w_rx_valid_n = r_rx_s2;
               w_rx_state_n = UART_IDLE;
            end
         end
         default: w_rx_state_n = UART_IDLE;
      endcase
   end

   assign o_txd      = r_txd;
   assign o_rx_valid = r_rx_valid;
   assign o_rx_data  = r_rx_shift;

endmodule

// File: rtl/lowrisc_chip_top.sv
// lowRISC FPGA shell in bring-up form: clock buffer, reset stretcher, UART
// banner/echo console and parked SD/flash pins.
module lowrisc_chip_top
   import lowrisc_chip_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int unsigned RST_STRETCH  = DEF_RST_STRETCH
) (
   input  logic       clk_p,
   input  logic       clk_n,
   input  logic       rst_top,
   input  logic       rxd,
   output logic       txd,
   output logic       spi_cs,
   output logic       spi_sclk,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic       sd_reset,
   output logic       flash_ss,
   inout  wire  [3:0] flash_io
);

   localparam int unsigned RW = $clog2(RST_STRETCH + 1);

   logic          w_clk;
   logic          w_rst;
   logic          r_rst_q;
   logic [RW-1:0] r_rst_cnt;

   logic       w_tx_valid, w_tx_ready_c;
   logic [7:0] w_tx_data;
   logic       w_rx_valid;
   logic [7:0] w_rx_data;

   logic [3:0] r_ban_idx, w_ban_idx_n;
   logic       r_ban_done, w_ban_done_n;
   logic       r_hold_valid, w_hold_valid_n;
   logic [7:0] r_hold_data, w_hold_data_n;
   logic       w_unused;

   // Behavioural differential input buffer
   assign w_clk = clk_p;

   // rst_top feeds w_rst directly so a re-assertion takes effect on the very next edge
   always_ff @(posedge w_clk) begin
      r_rst_q <= rst_top;
      if (r_rst_q)                r_rst_cnt <= RW'(RST_STRETCH);
      else if (r_rst_cnt != '0)   r_rst_cnt <= r_rst_cnt - RW'(1);
   end

   assign w_rst = rst_top | r_rst_q | (r_rst_cnt != '0);

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_ban_idx    <= '0;
         r_ban_done   <= 1'b0;
         r_hold_valid <= 1'b0;
         r_hold_data  <= '0;
      end else begin
         r_ban_idx    <= w_ban_idx_n;
         r_ban_done   <= w_ban_done_n;
         r_hold_valid <= w_hold_valid_n;
         r_hold_data  <= w_hold_data_n;
      end
   end

   // Banner has priority; the single holding register drains only once it is done
   always_comb begin
      w_ban_idx_n    = r_ban_idx;
      w_ban_done_n   = r_ban_done;
      w_hold_valid_n = r_hold_valid;
      w_hold_data_n  = r_hold_data;
      w_tx_data      = r_hold_data;
      w_tx_valid     = 1'b0;
      if (!r_ban_done) begin
         w_tx_valid = ~w_rst;
         w_tx_data  = banner_byte(r_ban_idx);
      end else begin
         w_tx_valid = r_hold_valid & ~w_rst;
      end
      if (w_tx_valid && w_tx_ready_c) begin
         if (!r_ban_done) begin
            w_ban_idx_n = r_ban_idx + 4'd1;
            if (r_ban_idx == 4'(BANNER_LEN - 1)) w_ban_done_n = 1'b1;
         end else begin
            w_hold_valid_n = 1'b0;
         end
      end
      if (w_rx_valid && !r_hold_valid) begin
         w_hold_valid_n = 1'b1;
         w_hold_data_n  = w_rx_data;
      end
   end

   chip_uart #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .i_clk        (w_clk),
      .i_rst        (w_rst),
      .i_tx_valid   (w_tx_valid),
      .i_tx_data    (w_tx_data),
      .o_tx_ready_c (w_tx_ready_c),
      .o_txd        (txd),
      .i_rxd        (rxd),
      .o_rx_valid   (w_rx_valid),
      .o_rx_data    (w_rx_data)
   );

   // SD-card and flash stay parked in their reset values permanently
   assign spi_cs   = 1'b1;
   assign spi_sclk = 1'b0;
   assign spi_mosi = 1'b1;
   assign sd_reset = 1'b1;
   assign flash_ss = 1'b1;
   assign flash_io = 4'bzzzz;

   assign w_unused = ^{clk_n, spi_miso, flash_io};

endmodule

// File: tb/tb_lowrisc_chip_top.sv
// Directed bench for lowrisc_chip_top: reset stretch, boot banner, echo,
// framing/glitch rejection, overrun and mid-frame reset.
module tb_lowrisc_chip_top;

   localparam int unsigned CPB     = 16;
   localparam int unsigned STRETCH = 16;
   localparam int          FRAME   = 10 * CPB;

   logic       clk_p    = 1'b0;
   wire        clk_n;
   logic       rst_top  = 1'b1;
   logic       rxd      = 1'b1;
   logic       spi_miso = 1'b0;
   wire        txd, spi_cs, spi_sclk, spi_mosi, sd_reset, flash_ss;
   wire  [3:0] flash_io;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int t_stop_ctr = 0;

   logic [7:0] exp_banner [9] = '{8'h6C, 8'h6F, 8'h77, 8'h52, 8'h49,
                                  8'h53, 8'h43, 8'h0D, 8'h0A};

   // Bench pulls the flash bus to a known value; it only reads back if the DUT releases it
   assign flash_io = 4'hA;
   assign clk_n    = ~clk_p;

   always #5 clk_p = ~clk_p;
   always @(posedge clk_p) cyc <= cyc + 1;

   lowrisc_chip_top #(
      .CLKS_PER_BIT(CPB),
      .RST_STRETCH (STRETCH)
   ) dut (
      .clk_p    (clk_p),
      .clk_n    (clk_n),
      .rst_top  (rst_top),
      .rxd      (rxd),
      .txd      (txd),
      .spi_cs   (spi_cs),
      .spi_sclk (spi_sclk),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .sd_reset (sd_reset),
      .flash_ss (flash_ss),
      .flash_io (flash_io)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_pins(input string tag);
      check({tag, "_spi"}, 32'({spi_cs, spi_sclk, spi_mosi, sd_reset, flash_ss}), 32'b10111);
      check({tag, "_flash_io"}, 32'(flash_io), 32'hA);
   endtask

   task automatic apply_reset(input int hold);
      @(negedge clk_p) rst_top = 1'b1;
      @(negedge clk_p);
      check("rst_txd_next", 32'(txd), 1);
      repeat (hold) @(negedge clk_p);
      check("rst_txd_hold", 32'(txd), 1);
      check_pins("rst");
      rst_top = 1'b0;
      repeat (STRETCH) @(negedge clk_p);
      check("rst_stretch_hi", 32'(dut.w_rst), 1);
      @(negedge clk_p);
      check("rst_fall", 32'(dut.w_rst), 0);
      check("rst_fall_txd", 32'(txd), 1);
      @(negedge clk_p);
      check("banner_start", 32'(txd), 0);
   endtask

   task automatic get_tx(output logic [7:0] b, output int t, input int budget);
      int   n;
      logic s_start, s_stop;
      n = 0;
      b = 8'h00;
      t = cyc;
      while (txd !== 1'b0 && n < budget) begin
         @(negedge clk_p);
         n++;
      end
      check("tx_start_seen", 32'(txd), 0);
      if (txd !== 1'b0) return;
      t = cyc;
      repeat (CPB / 2) @(negedge clk_p);
      s_start = txd;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk_p);
         b[i] = txd;
      end
      repeat (CPB) @(negedge clk_p);
      s_stop = txd;
      check("tx_frame", 32'({s_start, s_stop}), 32'b01);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      @(negedge clk_p) rxd = 1'b0;
      repeat (CPB) @(negedge clk_p);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clk_p);
      end
      rxd = stop;
      t_stop_ctr = cyc + CPB / 2;
      repeat (CPB) @(negedge clk_p);
      rxd = 1'b1;
   endtask

   task automatic quiet(input int n, output logic saw_low);
      saw_low = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk_p);
         if (txd !== 1'b1) saw_low = 1'b1;
      end
   endtask

   initial begin
      logic [7:0] b;
      int         t, t_prev, n;
      logic       saw;

      // Reset stretch and banner
      apply_reset(13);
      t_prev = 0;
      for (int i = 0; i < 9; i++) begin
         get_tx(b, t, 400);
         check($sformatf("banner_%0d", i), 32'(b), 32'(exp_banner[i]));
         if (i > 0) check($sformatf("banner_gap_%0d", i), 32'(t - t_prev), 32'(FRAME));
         t_prev = t;
      end
      quiet(300, saw);
      check("idle_after_banner", 32'(saw), 0);
      check_pins("idle");

      // Echo
      fork
         send_rx(8'hA5, 1'b1);
         get_tx(b, t, 600);
      join
      check("echo_a5", 32'(b), 32'hA5);
      check("echo_latency", 32'((t > t_stop_ctr) && (t - t_stop_ctr <= 3 * CPB)), 1);

      // Framing error and glitch are both rejected
      fork
         send_rx(8'h5A, 1'b0);
         quiet(400, saw);
      join
      check("frame_err_no_echo", 32'(saw), 0);
      @(negedge clk_p) rxd = 1'b0;
      repeat (3) @(negedge clk_p);
      rxd = 1'b1;
      quiet(200, saw);
      check("glitch_no_echo", 32'(saw), 0);
      fork
         send_rx(8'h3C, 1'b1);
         get_tx(b, t, 600);
      join
      check("echo_3c", 32'(b), 32'h3C);

      // Overrun during banner: only the first byte is kept
      apply_reset(13);
      fork
         begin
            repeat (20) @(negedge clk_p);
            send_rx(8'h11, 1'b1);
            send_rx(8'h22, 1'b1);
            send_rx(8'h33, 1'b1);
         end
         begin
            for (int i = 0; i < 10; i++) begin
               get_tx(b, t, 400);
               if (i < 9) check($sformatf("ovr_banner_%0d", i), 32'(b), 32'(exp_banner[i]));
               else       check("ovr_echo_11", 32'(b), 32'h11);
            end
         end
      join
      quiet(600, saw);
      check("ovr_no_extra", 32'(saw), 0);

      // Reset during the third banner byte restarts the banner
      apply_reset(5);
      get_tx(b, t, 400);
      check("mid_b0", 32'(b), 32'h6C);
      get_tx(b, t, 400);
      check("mid_b1", 32'(b), 32'h6F);
      n = 0;
      while (txd !== 1'b0 && n < 40) begin
         @(negedge clk_p);
         n++;
      end
      repeat (4) @(negedge clk_p);
      check("mid_b2_start_low", 32'(txd), 0);
      apply_reset(4);
      get_tx(b, t, 400);
      check("mid_restart_6c", 32'(b), 32'h6C);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
